// File: rtl/station_mux_if.sv
// Station collector bus: four station request/data lanes in,
// one valid/ready word channel out, plus grant status.
interface station_mux_if #(
  parameter int DW = 4
);
  logic          Enable;
  logic [3:0]    req;
  logic [DW-1:0] lib_data;
  logic [DW-1:0] fire_data;
  logic [DW-1:0] school_data;
  logic [DW-1:0] rib_data;
  logic [3:0]    ack;
  logic [DW-1:0] Out;
  logic [1:0]    Sel_Mux;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  modport master (
    output Enable,
    output req,
    output lib_data,
    output fire_data,
    output school_data,
    output rib_data,
    output out_ready,
    input  ack,
    input  Out,
    input  Sel_Mux,
    input  out_valid,
    input  busy
  );

  modport slave (
    input  Enable,
    input  req,
    input  lib_data,
    input  fire_data,
    input  school_data,
    input  rib_data,
    input  out_ready,
    output ack,
    output Out,
    output Sel_Mux,
    output out_valid,
    output busy
  );
endinterface

// File: rtl/station_mux.sv
// Four-station round-robin collector onto one valid/ready channel.
// STATION_MUX_FIRE_PRIORITY_EN: fire_department (1) wins and preempts.
module station_mux #(
  parameter int DW       = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  station_mux_if.slave   bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state;
  logic [1:0]    sel;
  logic [1:0]    last;
  logic [3:0]    count;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic          found;
  logic          in_grant;
  logic          ov;
  logic          acc;
  logic          last_word;
  logic          preempt;
  logic          done;
  logic [DW-1:0] data [4];

  assign data[0] = bus.lib_data;
  assign data[1] = bus.fire_data;
  assign data[2] = bus.school_data;
  assign data[3] = bus.rib_data;

  // Scan last+1 .. last+4 so the just-served station comes last.
  always_comb begin
    win   = last;
    idx   = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`ifdef STATION_MUX_FIRE_PRIORITY_EN
    if (bus.req[1]) win = 2'd1;
`endif
  end

  assign in_grant  = (state == GRANT);
  assign ov        = in_grant & bus.Enable & bus.req[sel];
  assign acc       = ov & bus.out_ready;
  assign last_word = acc & (count == 4'(HOLD_MAX - 1));

`ifdef STATION_MUX_FIRE_PRIORITY_EN
  assign preempt = (sel != 2'd1) & bus.req[1] & (acc | ~ov);
`else
  assign preempt = 1'b0;
`endif

  assign done = ~bus.req[sel] | ~bus.Enable
              | last_word | preempt;

  assign bus.out_valid = ov;
  assign bus.Out       = ov ? data[sel] : '0;
  assign bus.ack       = acc ? (4'b0001 << sel) : 4'b0000;
  assign bus.Sel_Mux   = sel;
  assign bus.busy      = in_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 2'd0;
      last  <= 2'd3;
      count <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Enable && (bus.req != 4'b0000)) begin
            sel   <= win;
            count <= 4'd0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (acc) count <= count + 4'd1;
          if (done) begin
            state <= IDLE;
            last  <= sel;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_station_mux.sv
// Directed-vector bench for station_mux.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_station_mux;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  station_mux_if #(.DW(4)) bus ();

  station_mux #(
    .DW(4),
    .HOLD_MAX(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0] dv [4];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_idle(input string tag);
    #1;
    chk({tag, "_ov"}, int'(bus.out_valid), 0);
    chk({tag, "_out"}, int'(bus.Out), 0);
    chk({tag, "_ack"}, int'(bus.ack), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  task automatic expect_word(input string tag, input int s, input bit ackd);
    #1;
    chk({tag, "_sel"}, int'(bus.Sel_Mux), s);
    chk({tag, "_ov"}, int'(bus.out_valid), 1);
    chk({tag, "_out"}, int'(bus.Out), int'(dv[s]));
    chk({tag, "_ack"}, int'(bus.ack), ackd ? (1 << s) : 0);
    chk({tag, "_busy"}, int'(bus.busy), 1);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.Enable      = 1'b1;
    bus.req         = 4'b0000;
    bus.out_ready   = 1'b1;
    bus.lib_data    = dv[0];
    bus.fire_data   = dv[1];
    bus.school_data = dv[2];
    bus.rib_data    = dv[3];
    @(negedge clk);
    @(negedge clk);
    chk("rst_ov", int'(bus.out_valid), 0);
    chk("rst_out", int'(bus.Out), 0);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_sel", int'(bus.Sel_Mux), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
  endtask

  int order [5];
  bit got;

  initial begin
    dv[0] = 4'hA;
    dv[1] = 4'h6;
    dv[2] = 4'h7;
    dv[3] = 4'h8;
    order = '{0, 1, 2, 3, 0};

    // single requester, full burst
    do_reset();
    bus.req = 4'b0001;
    expect_idle("t1_idle");
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      expect_word("t1_w", 0, 1'b1);
    end
    @(negedge clk);
    bus.req = 4'b0000;
    expect_idle("t1_end");

    // all requesting: round-robin with one idle gap
    do_reset();
    bus.req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      if (b != 0) @(negedge clk);
      expect_idle("t2_gap");
      for (int w = 0; w < 4; w++) begin
        @(negedge clk);
        expect_word("t2_w", order[b], 1'b1);
      end
    end
    @(negedge clk);
    bus.req = 4'b0000;
    expect_idle("t2_end");

    // downstream stall on station 2
    do_reset();
    bus.req = 4'b0100;
    expect_idle("t3_idle");
    @(negedge clk);
    expect_word("t3_w1", 2, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.fire_data = 4'(c);
      bus.req[0]    = c[0];
      expect_word("t3_stall", 2, 1'b0);
    end
    bus.fire_data = dv[1];
    bus.req       = 4'b0100;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      expect_word("t3_resume", 2, 1'b1);
    end
    @(negedge clk);
    bus.req = 4'b0000;
    expect_idle("t3_end");

    // Enable drop ends station 3 grant
    do_reset();
    bus.req = 4'b1000;
    expect_idle("t4_idle");
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      expect_word("t4_w", 3, 1'b1);
    end
    @(negedge clk);
    bus.Enable = 1'b0;
    #1;
    chk("t4_dis_ov", int'(bus.out_valid), 0);
    chk("t4_dis_out", int'(bus.Out), 0);
    chk("t4_dis_ack", int'(bus.ack), 0);
    @(negedge clk);
    bus.Enable = 1'b1;
    bus.req    = 4'b1001;
    expect_idle("t4_back");
    @(negedge clk);
    expect_word("t4_next", 0, 1'b1);

    // asynchronous reset mid-burst
    do_reset();
    bus.req = 4'b0001;
    expect_idle("t5_idle");
    @(negedge clk);
    expect_word("t5_w1", 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ov", int'(bus.out_valid), 0);
    chk("t5_rst_out", int'(bus.Out), 0);
    chk("t5_rst_ack", int'(bus.ack), 0);
    chk("t5_rst_busy", int'(bus.busy), 0);
    chk("t5_rst_sel", int'(bus.Sel_Mux), 0);
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'b0100;
    got     = 1'b0;
    for (int c = 0; c < 3 && !got; c++) begin
      #1;
      if (bus.out_valid && bus.Sel_Mux == 2'd2) got = 1'b1;
      else @(negedge clk);
    end
    chk("t5_regrant", int'(got), 1);

    // fire request arriving during station 0 burst
    do_reset();
    bus.req = 4'b0001;
    expect_idle("t6_idle");
    @(negedge clk);
    bus.req = 4'b0011;
    expect_word("t6_w1", 0, 1'b1);
`ifdef STATION_MUX_FIRE_PRIORITY_EN
    @(negedge clk);
    expect_idle("t6_pre");
`else
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      expect_word("t6_rest", 0, 1'b1);
    end
    @(negedge clk);
    expect_idle("t6_gap");
`endif
    @(negedge clk);
    expect_word("t6_fire", 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
